icache_nway: RTL and testbench
==============================

// Module: icache_nway
// PURPOSE
//  Parametrised N-way set-associative instruction cache with multi-word blocks.
//  Successor to the direct-mapped one-word icache.
//  Sits between the fetch stage (imem* side) and the memory controller/arbiter (i* side).
//  Fills a missed block word-by-word, and replaces the way after the most recently used one.
// PARAMETERS
//  WAYS       2   ways per set (power of 2, >=1)
//  SETS       8   sets (power of 2, >=2)
//  BLK_WORDS  2   32-bit words per block (power of 2, >=1)
//  Derived: WOFF_W=log2(BLK_WORDS), IDX_W=log2(SETS), TAG_W=30-WOFF_W-IDX_W
// PORTS
//  CLK          in   1   clock, rising edge
//  nRST         in   1   async active-low reset
//  imemREN      in   1   fetch request
//  imemaddr     in   32  fetch byte address (bits[1:0] ignored)
//  ihit         out  1   requested word valid this cycle
//  imemload     out  32  requested word; 0 when ihit=0
//  iinv         in   1   one-cycle pulse: invalidate entire cache
//  iREN         out  1   memory read request
//  iaddr        out  32  memory word address, bits[1:0]=0
//  iwait        in   1   memory busy; data valid on the cycle iwait=0
//  iload        in   32  memory read data
//  hit_cnt      out  32  saturating count of hit cycles
//  miss_cnt     out  32  saturating count of misses (fills started)
// BEHAVIOUR
//  Address split: [1:0] byte, [WOFF_W+1:2] word offset, next IDX_W bits index, top TAG_W bits tag.
//  Per-set storage: WAYS x {valid, tag, BLK_WORDS words}, plus a victim pointer vptr (log2 WAYS bits).
//  Reset (async, nRST=0):
//   all valid=0, vptr=0, state=IDLE, word counter=0, counters=0.
//   Outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
//  FSM states:
//   IDLE:
//    - Combinational lookup. ihit=imemREN & valid & tag match in some way; imemload from that way, same cycle (0-cycle hit latency).
//    - On hit edge: vptr[idx] <= (hitway+1) mod WAYS; hit_cnt++.
//    - If imemREN & no match: latch tag/idx and victim way = vptr[idx]; counter k=0; miss_cnt++; -> FETCH.
//   FETCH:
//    - iREN=1; iaddr={tag,idx,k,2'b00}; ihit=0.
//    - On cycle with iwait=0: buffer word k <= iload.
//    - If k<BLK_WORDS-1: k++ and stay. Else -> FILL.
//   FILL (1 cycle):
//    - iREN=0. Write victim way: valid=1, latched tag, all buffered words.
//    - vptr[idx] <= (victim+1) mod WAYS. -> IDLE; the re-presented request hits next cycle.
//  Miss penalty = sum of memory latencies + 2 cycles (IDLE detect, FILL).
//  The fill always starts at word 0 of the block (no critical-word-first). The requested offset does not matter.
//  imemaddr may change during FETCH; the latched address is used, and the new address is looked up on return to IDLE.
//  iinv=1 in any state:
//   - all valid<=0 and vptr<=0 at the edge.
//   - If in FETCH/FILL: the fill is aborted and nothing is written; -> IDLE, iREN drops next cycle.
//   - ihit is forced 0 during the iinv cycle.
//  Miss does not bump hit_cnt; a word is counted each cycle ihit=1.
//  Counters saturate at 32'hFFFF_FFFF; they are cleared only by reset.
//  WAYS=1 degenerates to direct-mapped (vptr unused, always 0).
//  nRST mid-FETCH: immediate return to IDLE and all-invalid; iREN=0 asynchronously.
// TESTING
//  1. Cold miss, WAYS=2,SETS=8,BLK=2, iwait 2 cyc/word: REN addr 0x0000_0040.
//     Required: iaddr 0x40 then 0x44, FILL, then ihit=1 with imemload=mem[0x40]; miss_cnt=1.
//  2. Spatial hit: after test 1, REN 0x44 -> ihit same cycle, no iREN, hit_cnt increments.
//  3. Conflict: fill 0x40 (way0), 0x440 (way1), touch 0x40, miss 0x840.
//     Required: 0x440's way is replaced; 0x40 still hits; 0x440 misses.
//  4. Invalidate mid-fill: iinv pulsed while iaddr=0x44.
//     Required: iREN=0 next cycle; REN 0x40 then misses and refetches from 0x40.
//  5. Async reset during FETCH:
//     Required: iREN/ihit low without a clock edge; all prior lines miss afterwards.
//  6. Param sweep WAYS=4,SETS=4,BLK=4 random stream vs reference model: every ihit word matches memory.
//     Counters saturate when preloaded via force at 0xFFFF_FFFF.

Source files
------------

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with multi-word blocks and word-serial refill.
// Victim selection: the way after the most recently used one in each set.
module icache_nway #(
    parameter int unsigned WAYS      = 2,
    parameter int unsigned SETS      = 8,
    parameter int unsigned BLK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iinv,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned WOFF_W = $clog2(BLK_WORDS);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = 30 - WOFF_W - IDX_W;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned K_W    = (WOFF_W > 0) ? WOFF_W : 1;

    typedef enum logic [1:0] {StIdle, StFetch, StFill} state_e;

    state_e             r_state;
    logic [K_W-1:0]     r_k;
    logic [TAG_W-1:0]   r_ltag;
    logic [IDX_W-1:0]   r_lidx;
    logic [WAY_W-1:0]   r_victim;
    logic [31:0]        r_hit_cnt;
    logic [31:0]        r_miss_cnt;

    logic [WAYS-1:0]    r_valid [SETS];
    logic [WAY_W-1:0]   r_vptr  [SETS];
    logic [TAG_W-1:0]   r_tags  [SETS][WAYS];
    logic [31:0]        r_data  [SETS][WAYS][BLK_WORDS];
    logic [31:0]        r_buf   [BLK_WORDS];

    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_idx;
    logic [K_W-1:0]     w_woff;
    logic               w_match;
    logic [WAY_W-1:0]   w_hway;
    logic               w_lookup;
    logic               w_miss;
    logic [31:0]        w_fetch_addr;

    function automatic logic [WAY_W-1:0] next_way(input logic [WAY_W-1:0] way);
        if (WAYS == 1) return '0;
        return way + WAY_W'(1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    assign w_tag  = TAG_W'(imemaddr >> (2 + WOFF_W + IDX_W));
    assign w_idx  = IDX_W'(imemaddr >> (2 + WOFF_W));
    assign w_woff = (BLK_WORDS > 1) ? K_W'(imemaddr >> 2) : '0;

    always_comb begin
        w_match = 1'b0;
        w_hway  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_match && r_valid[w_idx][w] && (r_tags[w_idx][w] == w_tag)) begin
                w_match = 1'b1;
                w_hway  = WAY_W'(w);
            end
        end
    end

    // Lookups only happen in IDLE; an invalidate cycle never reports a hit.
    assign w_lookup = (r_state == StIdle) && imemREN && !iinv;
    assign w_miss   = w_lookup && !w_match;
    assign ihit     = w_lookup && w_match;
    assign imemload = ihit ? r_data[w_idx][w_hway][w_woff] : 32'd0;

    assign w_fetch_addr = (32'(r_ltag) << (2 + WOFF_W + IDX_W))
                        | (32'(r_lidx) << (2 + WOFF_W))
                        | ((BLK_WORDS > 1) ? (32'(r_k) << 2) : 32'd0);

    assign iREN     = (r_state == StFetch);
    assign iaddr    = iREN ? w_fetch_addr : 32'd0;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= StIdle;
            r_k        <= '0;
            r_ltag     <= '0;
            r_lidx     <= '0;
            r_victim   <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_vptr[s]  <= '0;
            end
        end else begin
            if (ihit) r_hit_cnt <= sat_inc(r_hit_cnt);
            if (iinv) begin
                // Invalidate wins over everything, including an in-flight fill.
                for (int s = 0; s < SETS; s++) begin
                    r_valid[s] <= '0;
                    r_vptr[s]  <= '0;
                end
                r_state <= StIdle;
                r_k     <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (ihit) begin
                            r_vptr[w_idx] <= next_way(w_hway);
                        end else if (w_miss) begin
                            r_ltag     <= w_tag;
                            r_lidx     <= w_idx;
                            r_victim   <= r_vptr[w_idx];
                            r_k        <= '0;
                            r_miss_cnt <= sat_inc(r_miss_cnt);
                            r_state    <= StFetch;
                        end
                    end
                    StFetch: begin
                        if (!iwait) begin
                            if (r_k == K_W'(BLK_WORDS - 1)) r_state <= StFill;
                            else                            r_k     <= r_k + K_W'(1);
                        end
                    end
                    StFill: begin
                        r_valid[r_lidx][r_victim] <= 1'b1;
                        r_vptr[r_lidx]            <= next_way(r_victim);
                        r_k                       <= '0;
                        r_state                   <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    // Payload arrays carry no reset; the valid bits alone decide what is live.
    always_ff @(posedge CLK) begin
        if ((r_state == StFetch) && !iwait) r_buf[r_k] <= iload;
        if ((r_state == StFill) && !iinv) begin
            r_tags[r_lidx][r_victim] <= r_ltag;
            for (int b = 0; b < BLK_WORDS; b++) r_data[r_lidx][r_victim][b] <= r_buf[b];
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Bench for icache_nway: directed scenarios on a 2-way/8-set/2-word cache and a
// randomized stream on a 4-way/4-set/4-word cache against a set-level reference model.
module tb_icache_nway;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic nRST = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // DUT A: WAYS=2, SETS=8, BLK_WORDS=2
    logic        a_ren = 1'b0, a_inv = 1'b0, a_iwait = 1'b1;
    logic [31:0] a_addr = '0, a_iload = '0;
    logic        a_ihit, a_iren;
    logic [31:0] a_load, a_iaddr, a_hcnt, a_mcnt;

    icache_nway #(.WAYS(2), .SETS(8), .BLK_WORDS(2)) u_dut (
        .CLK(CLK), .nRST(nRST), .imemREN(a_ren), .imemaddr(a_addr), .ihit(a_ihit),
        .imemload(a_load), .iinv(a_inv), .iREN(a_iren), .iaddr(a_iaddr), .iwait(a_iwait),
        .iload(a_iload), .hit_cnt(a_hcnt), .miss_cnt(a_mcnt)
    );

    // DUT B: WAYS=4, SETS=4, BLK_WORDS=4
    logic        b_ren = 1'b0, b_inv = 1'b0, b_iwait = 1'b1;
    logic [31:0] b_addr = '0, b_iload = '0;
    logic        b_ihit, b_iren;
    logic [31:0] b_load, b_iaddr, b_hcnt, b_mcnt;

    icache_nway #(.WAYS(4), .SETS(4), .BLK_WORDS(4)) u_dut2 (
        .CLK(CLK), .nRST(nRST), .imemREN(b_ren), .imemaddr(b_addr), .ihit(b_ihit),
        .imemload(b_load), .iinv(b_inv), .iREN(b_iren), .iaddr(b_iaddr), .iwait(b_iwait),
        .iload(b_iload), .hit_cnt(b_hcnt), .miss_cnt(b_mcnt)
    );

    // Memory A: two busy cycles per word, then data.
    int          a_cnt = 0;
    logic [31:0] a_fetched[$];
    always @(negedge CLK) begin
        if (a_iren) begin
            if (a_cnt == 2) begin
                a_iwait = 1'b0; a_iload = memval(a_iaddr); a_fetched.push_back(a_iaddr); a_cnt = 0;
            end else begin
                a_iwait = 1'b1; a_iload = 32'hDEAD_BEEF; a_cnt++;
            end
        end else begin
            a_iwait = 1'b1; a_cnt = 0;
        end
    end

    // Memory B: random 0..2 busy cycles per word.
    int          b_cnt = 0, b_lat = 1;
    logic [31:0] b_fetched[$];
    always @(negedge CLK) begin
        if (b_iren) begin
            if (b_cnt >= b_lat) begin
                b_iwait = 1'b0; b_iload = memval(b_iaddr); b_fetched.push_back(b_iaddr);
                b_cnt = 0; b_lat = int'($urandom_range(0, 2));
            end else begin
                b_iwait = 1'b1; b_iload = 32'hDEAD_BEEF; b_cnt++;
            end
        end else begin
            b_iwait = 1'b1; b_cnt = 0;
        end
    end

    task automatic req_a(input logic [31:0] addr, output logic first, output logic got,
                         output logic [31:0] data, output int cyc);
        @(negedge CLK); a_ren = 1'b1; a_addr = addr; #1;
        first = a_ihit; cyc = 0;
        while (!a_ihit && cyc < 100) begin @(negedge CLK); #1; cyc++; end
        got = a_ihit; data = a_load;
        @(negedge CLK); a_ren = 1'b0;
    endtask

    task automatic req_b(input logic [31:0] addr, output logic first, output logic got,
                         output logic [31:0] data);
        int cyc;
        @(negedge CLK); b_ren = 1'b1; b_addr = addr; #1;
        first = b_ihit; cyc = 0;
        while (!b_ihit && cyc < 100) begin @(negedge CLK); #1; cyc++; end
        got = b_ihit; data = b_load;
        @(negedge CLK); b_ren = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; a_ren = 1'b1; a_addr = 32'h40;
        repeat (3) @(negedge CLK);
        #1;
        n_tests++; if (a_ihit !== 1'b0) begin n_fail++; $display("FAIL reset_ihit: got %0b want 0", a_ihit); end
        n_tests++; if (a_load !== 32'd0) begin n_fail++; $display("FAIL reset_imemload: got %h want 0", a_load); end
        n_tests++; if (a_iren !== 1'b0) begin n_fail++; $display("FAIL reset_iREN: got %0b want 0", a_iren); end
        n_tests++; if (a_iaddr !== 32'd0) begin n_fail++; $display("FAIL reset_iaddr: got %h want 0", a_iaddr); end
        n_tests++; if (a_hcnt !== 32'd0 || a_mcnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", a_hcnt, a_mcnt); end
        @(negedge CLK); a_ren = 1'b0; nRST = 1'b1;
    endtask

    task automatic test_cold_miss();
        logic first, got; logic [31:0] data; int cyc;
        a_fetched.delete();
        req_a(32'h40, first, got, data, cyc);
        n_tests++; if (first !== 1'b0) begin n_fail++; $display("FAIL cold_first: got hit %0b want 0", first); end
        n_tests++; if (got !== 1'b1 || cyc != 8) begin
            n_fail++; $display("FAIL cold_latency: got hit=%0b after %0d cycles want 1 after 8", got, cyc); end
        n_tests++; if (data !== memval(32'h40)) begin
            n_fail++; $display("FAIL cold_data: got %h want %h", data, memval(32'h40)); end
        n_tests++; if (a_fetched.size() != 2 || a_fetched[0] !== 32'h40 || a_fetched[1] !== 32'h44) begin
            n_fail++; $display("FAIL cold_iaddr_seq: got %p want 0x40,0x44", a_fetched); end
        #1;
        n_tests++; if (a_mcnt !== 32'd1) begin n_fail++; $display("FAIL cold_miss_cnt: got %0d want 1", a_mcnt); end
    endtask

    task automatic test_spatial_hit();
        @(negedge CLK); a_ren = 1'b1; a_addr = 32'h44; #1;
        n_tests++; if (a_ihit !== 1'b1) begin n_fail++; $display("FAIL spatial_ihit: got %0b want 1", a_ihit); end
        n_tests++; if (a_load !== memval(32'h44)) begin
            n_fail++; $display("FAIL spatial_data: got %h want %h", a_load, memval(32'h44)); end
        n_tests++; if (a_iren !== 1'b0) begin n_fail++; $display("FAIL spatial_iREN: got %0b want 0", a_iren); end
        @(negedge CLK); a_ren = 1'b0; #1;
        n_tests++; if (a_hcnt !== 32'd2) begin n_fail++; $display("FAIL spatial_hit_cnt: got %0d want 2", a_hcnt); end
    endtask

    task automatic test_conflict();
        logic first, got; logic [31:0] data; int cyc;
        logic [31:0] seq [5];
        logic        exp_first [5];
        seq = '{32'h440, 32'h40, 32'h840, 32'h40, 32'h440};
        exp_first = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            req_a(seq[i], first, got, data, cyc);
            n_tests++; if (first !== exp_first[i]) begin
                n_fail++; $display("FAIL conflict_hit[%0d] addr %h: got %0b want %0b", i, seq[i], first, exp_first[i]); end
            n_tests++; if (got !== 1'b1 || data !== memval(seq[i])) begin
                n_fail++; $display("FAIL conflict_data[%0d]: got %0b/%h want 1/%h", i, got, data, memval(seq[i])); end
        end
        #1;
        n_tests++; if (a_mcnt !== 32'd4) begin n_fail++; $display("FAIL conflict_miss_cnt: got %0d want 4", a_mcnt); end
    endtask

    task automatic test_inv_mid_fill();
        logic first, got; logic [31:0] data; int cyc;
        @(negedge CLK); a_inv = 1'b1;
        @(negedge CLK); a_inv = 1'b0; a_ren = 1'b1; a_addr = 32'h40;
        cyc = 0;
        do begin @(negedge CLK); #1; cyc++; end while (!(a_iren && a_iaddr == 32'h44) && cyc < 50);
        n_tests++; if (!(a_iren === 1'b1 && a_iaddr === 32'h44)) begin
            n_fail++; $display("FAIL inv_reach_word1: got iREN=%0b iaddr=%h want 1/0x44", a_iren, a_iaddr); end
        a_inv = 1'b1; a_ren = 1'b0;
        @(negedge CLK); a_inv = 1'b0; #1;
        n_tests++; if (a_iren !== 1'b0) begin n_fail++; $display("FAIL inv_iREN_drop: got %0b want 0", a_iren); end
        a_fetched.delete();
        req_a(32'h40, first, got, data, cyc);
        n_tests++; if (first !== 1'b0 || a_fetched.size() == 0 || a_fetched[0] !== 32'h40) begin
            n_fail++; $display("FAIL inv_refetch: got first=%0b fetched=%p want miss from 0x40", first, a_fetched); end
        n_tests++; if (got !== 1'b1 || data !== memval(32'h40)) begin
            n_fail++; $display("FAIL inv_refetch_data: got %0b/%h want 1/%h", got, data, memval(32'h40)); end
        @(negedge CLK); a_ren = 1'b1; a_addr = 32'h40; a_inv = 1'b1; #1;
        n_tests++; if (a_ihit !== 1'b0) begin n_fail++; $display("FAIL inv_cycle_ihit: got %0b want 0", a_ihit); end
        @(negedge CLK); a_inv = 1'b0; a_ren = 1'b0;
        req_a(32'h40, first, got, data, cyc);
        n_tests++; if (first !== 1'b0 || got !== 1'b1) begin
            n_fail++; $display("FAIL inv_clears_line: got first=%0b got=%0b want 0/1", first, got); end
    endtask

    task automatic test_async_reset();
        logic first, got; logic [31:0] data; int cyc;
        @(negedge CLK); a_ren = 1'b1; a_addr = 32'h440;
        cyc = 0;
        do begin @(negedge CLK); #1; cyc++; end while (!a_iren && cyc < 20);
        n_tests++; if (a_iren !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_start: got iREN %0b want 1", a_iren); end
        #1; nRST = 1'b0; a_addr = 32'h40; #1;
        n_tests++; if (a_iren !== 1'b0 || a_ihit !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_outputs: got iREN=%0b ihit=%0b want 0/0", a_iren, a_ihit); end
        n_tests++; if (a_hcnt !== 32'd0 || a_mcnt !== 32'd0) begin
            n_fail++; $display("FAIL rst_async_counters: got %h/%h want 0/0", a_hcnt, a_mcnt); end
        @(negedge CLK); nRST = 1'b1; a_ren = 1'b0;
        req_a(32'h40, first, got, data, cyc);
        n_tests++; if (first !== 1'b0 || got !== 1'b1 || data !== memval(32'h40)) begin
            n_fail++; $display("FAIL rst_lines_gone: got first=%0b got=%0b data=%h want 0/1/%h",
                                first, got, data, memval(32'h40)); end
    endtask

    task automatic test_random_stream();
        bit          m_v [4][4];
        int unsigned m_t [4][4];
        int          m_vp [4];
        int          m_hits, m_miss, hw, s, v;
        int unsigned blk, t;
        logic        first, got; logic [31:0] data, addr;
        for (int i = 0; i < 4; i++) begin
            m_vp[i] = 0;
            for (int j = 0; j < 4; j++) begin m_v[i][j] = 1'b0; m_t[i][j] = 0; end
        end
        m_hits = 0; m_miss = 0;
        for (int n = 0; n < 150; n++) begin
            addr = $urandom_range(0, 32'h5FF) & 32'hFFFF_FFFC;
            blk = addr >> 4; s = int'(blk % 4); t = blk / 4; hw = -1;
            for (int w = 0; w < 4; w++) if (hw < 0 && m_v[s][w] && m_t[s][w] == t) hw = w;
            b_fetched.delete();
            req_b(addr, first, got, data);
            n_tests++; if (first !== (hw >= 0)) begin
                n_fail++; $display("FAIL rand_hit[%0d] addr %h: got %0b want %0b", n, addr, first, hw >= 0); end
            n_tests++; if (got !== 1'b1 || data !== memval(addr)) begin
                n_fail++; $display("FAIL rand_data[%0d] addr %h: got %0b/%h want 1/%h", n, addr, got, data, memval(addr)); end
            if (hw >= 0) begin
                m_vp[s] = (hw + 1) % 4;
            end else begin
                m_miss++;
                v = m_vp[s]; m_v[s][v] = 1'b1; m_t[s][v] = t; m_vp[s] = (v + 1) % 4;
                n_tests++; if (b_fetched.size() != 4 || b_fetched[0] !== (blk << 4) || b_fetched[1] !== ((blk << 4) + 4)
                               || b_fetched[2] !== ((blk << 4) + 8) || b_fetched[3] !== ((blk << 4) + 12)) begin
                    n_fail++; $display("FAIL rand_fill_seq[%0d]: got %p want block %h words 0..3", n, b_fetched, blk << 4); end
            end
            m_hits++;
        end
        #1;
        n_tests++; if (b_hcnt !== 32'(m_hits) || b_mcnt !== 32'(m_miss)) begin
            n_fail++; $display("FAIL rand_counters: got %0d/%0d want %0d/%0d", b_hcnt, b_mcnt, m_hits, m_miss); end
        // Saturation: preload then hit a line known to be resident.
        force u_dut2.r_hit_cnt = 32'hFFFF_FFFF; #1; release u_dut2.r_hit_cnt;
        req_b(addr, first, got, data);
        #1;
        n_tests++; if (first !== 1'b1 || b_hcnt !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sat_hit_cnt: got first=%0b cnt=%h want 1/ffffffff", first, b_hcnt); end
        force u_dut2.r_miss_cnt = 32'hFFFF_FFFF; #1; release u_dut2.r_miss_cnt;
        req_b(32'h8000_0000, first, got, data);
        #1;
        n_tests++; if (first !== 1'b0 || b_mcnt !== 32'hFFFF_FFFF || b_hcnt !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sat_miss_cnt: got first=%0b miss=%h hit=%h want 0/ffffffff/ffffffff",
                                first, b_mcnt, b_hcnt); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_spatial_hit();
        test_conflict();
        test_inv_mid_fill();
        test_async_reset();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
